// File: rtl/bus_wait_ctrl_pkg.sv
// Shared types and helpers for the bus wait-state sequencer.
package bus_wait_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int TO_W = 10;

    function automatic logic [3:0] clamp_waits(input int n);
        if (n > 8) begin
            return 4'd8;
        end else if (n < 0) begin
            return 4'd0;
        end else begin
            return n[3:0];
        end
    endfunction

    // n leading zeros, MSB first, so the register shifts out n not-ready clocks.
    function automatic logic [7:0] therm_pattern(input logic [3:0] n);
        logic [7:0] mask;
        if (n >= 4'd8) begin
            return 8'h00;
        end
        mask = 8'hFF << (4'd8 - n);
        return ~mask;
    endfunction

endpackage

// File: rtl/bus_wait_ctrl_rdy_sync.sv
// Two-flop synchronizer for the asynchronous S-100 RDY line; resets to ready.
module rdy_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            q       <= 1'b1;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/bus_wait_ctrl.sv
// Wait-state sequencer: classifies bus cycles, drives the external wait shift
// register and merges its output with synchronized RDY into cpu_ready.
module bus_wait_ctrl
    import bus_wait_pkg::*;
#(
    parameter int IO_WAITS  = 4,
    parameter int ROM_WAITS = 2,
    parameter int MEM_WAITS = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_sync,
    input  logic       io_sel,
    input  logic       rom_sel,
    input  logic       cycle_done,
    input  logic       ext_rdy,
    input  logic       shreg_q,
    output logic       wait_load,
    output logic [7:0] wait_pattern,
    output logic       wait_serin,
    output logic       cpu_ready,
    output logic       bus_err
);

    localparam logic [3:0]      IO_N   = clamp_waits(IO_WAITS);
    localparam logic [3:0]      ROM_N  = clamp_waits(ROM_WAITS);
    localparam logic [3:0]      MEM_N  = clamp_waits(MEM_WAITS);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state, state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [3:0]      sel_n;
    logic            rdy_s;
    logic            shift_rdy;
    logic            timeout;

    rdy_sync u_rdy_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ext_rdy),
        .q     (rdy_s)
    );

    assign wait_serin = 1'b1;
    assign shift_rdy  = shreg_q & rdy_s;
    assign timeout    = (to_cnt >= TO_LIM);

    // I/O outranks ROM when both selects are asserted.
    always_comb begin
        sel_n = MEM_N;
        if (io_sel) begin
            sel_n = IO_N;
        end else if (rom_sel) begin
            sel_n = ROM_N;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_load = 1'b0;
        cpu_ready = 1'b1;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_sync) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                wait_load = 1'b1;
                cpu_ready = 1'b0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                cpu_ready = shift_rdy;
                if (cycle_done) begin
                    state_nxt = IDLE;
                end else if (shift_rdy) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    // Release the CPU rather than hang on an absent device.
                    bus_err   = 1'b1;
                    cpu_ready = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (cycle_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_pattern <= 8'hFF;
            to_cnt       <= '0;
        end else begin
            if (state == IDLE && cpu_sync) begin
                wait_pattern <= therm_pattern(sel_n);
            end
            if (state == LOAD) begin
                to_cnt <= '0;
            end else if (state == SHIFT && to_cnt != '1) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed bench for bus_wait_ctrl with a behavioural wait shift register attached.
module tb_bus_wait_ctrl;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       cpu_sync   = 1'b0;
    logic       io_sel     = 1'b0;
    logic       rom_sel    = 1'b0;
    logic       cycle_done = 1'b0;
    logic       ext_rdy    = 1'b1;
    logic       shreg_q;
    logic       wait_load;
    logic [7:0] wait_pattern;
    logic       wait_serin;
    logic       cpu_ready;
    logic       bus_err;
    logic [7:0] sr = 8'hFF;

    int checks     = 0;
    int failures   = 0;
    int err_pulses = 0;
    int loads      = 0;

    always #5 clk = ~clk;

    bus_wait_ctrl #(
        .IO_WAITS  (4),
        .ROM_WAITS (2),
        .MEM_WAITS (0),
        .TIMEOUT   (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_sync     (cpu_sync),
        .io_sel       (io_sel),
        .rom_sel      (rom_sel),
        .cycle_done   (cycle_done),
        .ext_rdy      (ext_rdy),
        .shreg_q      (shreg_q),
        .wait_load    (wait_load),
        .wait_pattern (wait_pattern),
        .wait_serin   (wait_serin),
        .cpu_ready    (cpu_ready),
        .bus_err      (bus_err)
    );

    // Parallel-load shift register, MSB out first.
    always @(posedge clk) sr <= wait_load ? wait_pattern : {sr[6:0], wait_serin};
    assign shreg_q = sr[7];

    always @(negedge clk) begin
        if (bus_err) err_pulses++;
        if (wait_load) loads++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic end_cycle;
        cycle_done = 1'b1;
        tick;
        cycle_done = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, l0, e0;

        tick; tick;
        chk("rst_ready", cpu_ready, 1);
        chk("rst_load", wait_load, 0);
        chk("rst_pat", wait_pattern, 8'hFF);
        chk("rst_err", bus_err, 0);
        chk("serin", wait_serin, 1);
        reset = 1'b0;
        tick; tick;

        // I/O cycle: 4 waits
        l0 = loads;
        cpu_sync = 1'b1; io_sel = 1'b1;
        tick;
        cpu_sync = 1'b0; io_sel = 1'b0;
        chk("io_load", wait_load, 1);
        chk("io_pat", wait_pattern, 8'h0F);
        n = 0;
        while (!cpu_ready && n < 50) begin n++; tick; end
        chk("io_low", n, 5);
        chk("io_loads", loads - l0, 1);
        tick; tick;
        chk("io_done_rdy", cpu_ready, 1);
        chk("io_done_load", wait_load, 0);
        end_cycle;
        chk("io_idle_rdy", cpu_ready, 1);

        // Memory cycle: 0 waits
        cpu_sync = 1'b1;
        tick;
        cpu_sync = 1'b0;
        chk("mem_pat", wait_pattern, 8'hFF);
        n = 0;
        while (!cpu_ready && n < 50) begin n++; tick; end
        chk("mem_low", n, 1);
        tick;
        end_cycle;

        // Both selects: I/O wins
        cpu_sync = 1'b1; io_sel = 1'b1; rom_sel = 1'b1;
        tick;
        cpu_sync = 1'b0; io_sel = 1'b0; rom_sel = 1'b0;
        chk("both_pat", wait_pattern, 8'h0F);
        n = 0;
        while (!cpu_ready && n < 50) begin n++; tick; end
        chk("both_low", n, 5);
        tick;
        end_cycle;

        // ROM cycle with ext_rdy held low past the shift-out
        ext_rdy = 1'b0;
        tick; tick; tick;
        e0 = err_pulses;
        cpu_sync = 1'b1; rom_sel = 1'b1;
        tick;
        cpu_sync = 1'b0; rom_sel = 1'b0;
        chk("rom_pat", wait_pattern, 8'h3F);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (cpu_ready) n++;
        end
        chk("rom_held", n, 0);
        ext_rdy = 1'b1;
        chk("rom_sync0", cpu_ready, 0);
        tick;
        chk("rom_sync1", cpu_ready, 0);
        tick;
        chk("rom_sync2", cpu_ready, 1);
        tick;
        chk("rom_noerr", err_pulses - e0, 0);
        end_cycle;

        // Timeout with ext_rdy stuck low, stray cpu_sync during SHIFT
        ext_rdy = 1'b0;
        tick; tick; tick;
        l0 = loads;
        e0 = err_pulses;
        cpu_sync = 1'b1; io_sel = 1'b1;
        tick;
        cpu_sync = 1'b0; io_sel = 1'b0;
        n = 0;
        while (!bus_err && n < 60) begin
            cpu_sync = (n == 4);
            io_sel   = (n == 4);
            tick;
            n++;
        end
        cpu_sync = 1'b0; io_sel = 1'b0;
        chk("to_clocks", n, 21);
        chk("to_ready", cpu_ready, 1);
        tick;
        chk("to_err_clr", bus_err, 0);
        chk("to_done_rdy", cpu_ready, 1);
        chk("to_pulses", err_pulses - e0, 1);
        chk("to_loads", loads - l0, 1);
        end_cycle;
        ext_rdy = 1'b1;
        tick; tick;

        // Asynchronous reset in the middle of SHIFT
        cpu_sync = 1'b1; io_sel = 1'b1;
        tick;
        cpu_sync = 1'b0; io_sel = 1'b0;
        tick;
        chk("pre_rst_low", cpu_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", cpu_ready, 1);
        chk("arst_load", wait_load, 0);
        chk("arst_pat", wait_pattern, 8'hFF);
        #1 reset = 1'b0;
        tick;
        chk("post_rst_ready", cpu_ready, 1);
        chk("post_rst_load", wait_load, 0);
        cpu_sync = 1'b1;
        tick;
        cpu_sync = 1'b0;
        chk("post_rst_sync", wait_load, 1);
        chk("post_rst_pat", wait_pattern, 8'hFF);
        tick; tick;
        end_cycle;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_wait_ctrl.md
# bus_wait_ctrl

Wait-state sequencer sitting directly upstream of the parallel-load wait shift register on the CPU bus path. It classifies each new bus cycle as I/O, ROM or memory. It then drives the register's load strobe, parallel pattern and serial input, and merges the register's serial output with the synchronized external S-100 RDY line into the single CPU ready signal. A timeout watchdog keeps the CPU from hanging on an absent device.

## Interface
Parameters:
- IO_WAITS, 4, wait states for I/O cycles (0-8, values >8 clamp to 8)
- ROM_WAITS, 2, wait states for ROM cycles (0-8, clamped)
- MEM_WAITS, 0, wait states for memory or unselected cycles (0-8, clamped)
- TIMEOUT, 255, max clocks spent in SHIFT before forced release (1-1023)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  CPU clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- cpu_sync  in  1  one-clock pulse marking start of a bus cycle
- io_sel  in  1  cycle targets I/O space (sampled with cpu_sync)
- rom_sel  in  1  cycle targets ROM (sampled with cpu_sync)
- cycle_done  in  1  CPU has finished the data phase; ends the cycle
- ext_rdy  in  1  asynchronous S-100 RDY, high = ready
- shreg_q  in  1  serial ready output of the wait shift register
- wait_load  out  1  load strobe to shift register (high = load)
- wait_pattern  out  8  parallel pattern to shift register
- wait_serin  out  1  serial input to shift register, tied 1
- cpu_ready  out  1  combined ready to CPU, high = proceed
- bus_err  out  1  one-clock pulse on timeout

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: cpu_ready=1, wait_load=0. A cpu_sync pulse selects n: io_sel gives IO_WAITS, else rom_sel gives ROM_WAITS, else MEM_WAITS (io has priority if both are set). The block registers wait_pattern = ~(8'hFF << (8-n)), MSB-first zeros: n=0 gives FF, n=1 gives 7F, n=2 gives 3F, n=8 gives 00. Next state is LOAD.
- LOAD: wait_load=1 for exactly one clock; cpu_ready=0. Next state is SHIFT. The timeout counter clears.
- SHIFT: wait_load=0. cpu_ready = shreg_q & rdy_s, where rdy_s is ext_rdy after a 2-flop synchronizer. When shreg_q & rdy_s is high, next state is DONE. When the counter reaches TIMEOUT, bus_err pulses, cpu_ready is forced to 1 and next state is DONE. cycle_done in SHIFT aborts to IDLE with no error.
- DONE: cpu_ready=1. cycle_done returns the block to IDLE.
- cpu_sync outside IDLE is ignored; no queuing.
- wait_pattern holds its last value outside LOAD.
- Reset (asynchronous, any state): state=IDLE, cpu_ready=1, wait_load=0, wait_pattern=8'hFF, bus_err=0, counter=0, synchronizer flops=1.
- The timeout counter is 10 bits and saturates; it never wraps.

## Timing
- cpu_sync is sampled at edge T. wait_load and the pattern are valid during T..T+1. The shift register loads at edge T+1, and shreg_q reflects pattern bit 7 after T+1.
- With n waits and ext_rdy high, cpu_ready is low for n+1 clocks (LOAD plus n shift clocks), then rises.
- ext_rdy has 2 clocks of synchronizer latency before it affects cpu_ready.
- bus_err is high for exactly the one clock on which SHIFT moves to DONE by timeout.
- If timeout and ready occur on the same clock, ready wins and there is no bus_err.

## Structure
- Package bus_wait_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - function clamp_waits (int to 4-bit, max 8)
  - function therm_pattern (n to 8-bit MSB-first zero mask)
  - localparam TO_W = 10
- One sub-module, rdy_sync: 2-flop synchronizer with asynchronous active-high reset to 1.
- The wait shift register itself stays outside this block and is instantiated beside it at the top level.

## Test plan
- Reset mid-SHIFT: assert reset asynchronously between edges → cpu_ready=1, wait_load=0, wait_pattern=FF immediately; state is IDLE on release.
- I/O cycle, IO_WAITS=4, ext_rdy=1, real shift register attached: cpu_sync with io_sel → wait_pattern=0F, wait_load high 1 clock, cpu_ready low 5 clocks, then high until cycle_done.
- Memory cycle, MEM_WAITS=0: cpu_sync with no select → pattern FF, cpu_ready low exactly 1 clock (LOAD).
- io_sel and rom_sel both high, ROM_WAITS=2: pattern uses IO_WAITS, so 0F, not 3F.
- ext_rdy held low 10 clocks past the shift-out, ROM cycle: cpu_ready stays low until 2 clocks after ext_rdy rises; bus_err stays 0.
- ext_rdy stuck low, TIMEOUT=20: bus_err pulses once 20 clocks into SHIFT, cpu_ready goes to 1, and a cpu_sync during SHIFT produces no second wait_load.
